// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - block copy engine for one single-port memory port
// Copies len words from src to dst in ascending order, one read then one write per word.
module mem_copy_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_r, dst_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  count, count_nxt;
  logic [ADDR_W-1:0] offset;
  logic              load;

  // words_done doubles as the word index i; the size cast wraps addresses modulo 2^ADDR_W
  assign offset     = ADDR_W'(count);
  assign words_done = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      src_r <= '0;
      dst_r <= '0;
      len_r <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (load) begin
        src_r <= src_addr;
        dst_r <= dst_addr;
        len_r <= len;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        // abort outranks start, even for a zero-length request
        if (start && !abort) begin
          count_nxt = '0;
          if (len != '0) begin
            load      = 1'b1;
            state_nxt = READ;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      READ: begin
        busy      = 1'b1;
        mem_addr  = src_r + offset;
        state_nxt = abort ? IDLE : WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_addr  = dst_r + offset;
        mem_wen   = 1'b1;
        mem_wdata = mem_rdata;
        count_nxt = count + LEN_W'(1);
        if (abort)                  state_nxt = IDLE;
        else if (count_nxt == len_r) state_nxt = DONE;
        else                        state_nxt = READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - self-checking bench for mem_copy_dma with a behavioural memory
// Expected writes are pushed per request from a shadow memory and compared against committed writes.
module tb_mem_copy_dma;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] src_addr, dst_addr, len;
  logic        abort;
  logic        busy, done, mem_wen;
  logic [15:0] words_done, mem_addr, mem_wdata, mem_rdata;

  logic        pre_we;
  logic [15:0] pre_addr, pre_data;
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [31:0] act_q[$];
  logic [31:0] exp_q[$];

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [15:0] exp_words;
    int          exp_cycles;
    int          glitch;
  } vec_t;
  vec_t vecs[7];

  mem_copy_dma #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .abort(abort), .busy(busy), .done(done), .words_done(words_done),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, write commits at the edge; committed writes are logged
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
      act_q.push_back({mem_addr, mem_wdata});
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_copy(input vec_t v, input int idx);
    int          base;
    int          cyc;
    logic [15:0] a, b;
    logic [31:0] e, got;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.src + 16'(i);
      b = v.dst + 16'(i);
      ref_mem[b] = ref_mem[a];
      exp_q.push_back({b, ref_mem[b]});
    end
    base = act_q.size();
    @(negedge clk);
    start = 1'b1; src_addr = v.src; dst_addr = v.dst; len = v.len;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 2 * int'(v.len) + 20) begin
      if (v.glitch != 0 && cyc == v.glitch) begin
        start = 1'b1; src_addr = 16'h0500; dst_addr = 16'h0600; len = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(v.exp_cycles));
    check($sformatf("v%0d_done_busy", idx), {30'd0, done, busy}, 32'h2);
    check($sformatf("v%0d_words", idx), {16'd0, words_done}, {16'd0, v.exp_words});
    check($sformatf("v%0d_nwrites", idx), 32'(act_q.size() - base), 32'(v.len));
    for (int k = 0; k < int'(v.len); k++) begin
      e   = exp_q.pop_front();
      got = (base + k < act_q.size()) ? act_q[base + k] : 32'hFFFF_FFFF;
      check($sformatf("v%0d_wr%0d", idx, k), got, e);
    end
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
  endtask

  initial begin
    int base, wcnt, cyc, seen_done;
    n_cmp = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; pre_we = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; pre_addr = '0; pre_data = '0;

    vecs[0] = '{16'h0010, 16'h0040, 16'd4, 16'd4, 9, 0};
    vecs[1] = '{16'h0010, 16'h0050, 16'd0, 16'd0, 1, 0};
    vecs[2] = '{16'hFFFE, 16'h0100, 16'd4, 16'd4, 9, 0};
    vecs[3] = '{16'h0020, 16'h0021, 16'd3, 16'd3, 7, 0};
    vecs[4] = '{16'h0041, 16'h0040, 16'd3, 16'd3, 7, 0};
    vecs[5] = '{16'h0080, 16'h0080, 16'd1, 16'd1, 3, 0};
    vecs[6] = '{16'h0010, 16'h0060, 16'd4, 16'd4, 9, 3};

    repeat (2) @(negedge clk);
    check("reset_outputs", {12'd0, busy, done, mem_wen, 1'b0, words_done}, 32'd0);
    check("reset_bus", {mem_addr, mem_wdata}, 32'd0);
    rst = 1'b1;

    preload(16'h0010, 16'hA0A0); preload(16'h0011, 16'hB1B1);
    preload(16'h0012, 16'hC2C2); preload(16'h0013, 16'hD3D3);
    preload(16'h0020, 16'h0005);
    preload(16'hFFFE, 16'h1111); preload(16'hFFFF, 16'h2222);
    preload(16'h0000, 16'h3333); preload(16'h0001, 16'h4444);
    preload(16'h0080, 16'h7777);
    preload(16'h0070, 16'hDEAD);
    for (int i = 0; i < 10; i++) preload(16'h0200 + 16'(i), 16'h5000 + 16'(i));

    for (int v = 0; v < 7; v++) run_copy(vecs[v], v);

    check("mem_40_43", {mem[16'h40], mem[16'h41]}, {16'hB1B1, 16'hC2C2});
    check("mem_42_43", {mem[16'h42], mem[16'h43]}, {16'hD3D3, 16'hD3D3});
    check("mem_21_22", {mem[16'h21], mem[16'h22]}, {16'h0005, 16'h0005});
    check("mem_23", {16'd0, mem[16'h23]}, 32'h0005);
    check("mem_100_101", {mem[16'h100], mem[16'h101]}, {16'h1111, 16'h2222});
    check("mem_102_103", {mem[16'h102], mem[16'h103]}, {16'h3333, 16'h4444});

    // Abort in the third WRITE cycle of a 10-word copy
    for (int i = 0; i < 3; i++) exp_q.push_back({16'h0300 + 16'(i), 16'h5000 + 16'(i)});
    base = act_q.size();
    @(negedge clk);
    start = 1'b1; src_addr = 16'h0200; dst_addr = 16'h0300; len = 16'd10;
    @(negedge clk);
    start = 1'b0;
    wcnt = 0; cyc = 0; seen_done = 0;
    while (cyc < 60) begin
      if (done) seen_done = 1;
      if (mem_wen) wcnt++;
      if (wcnt == 3) break;
      @(negedge clk);
      cyc++;
    end
    check("abort_reached", 32'(wcnt), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", {15'd0, busy, done, seen_done[0], words_done[13:0]}, {15'd0, 1'b0, 1'b0, 1'b0, 14'd3});
    @(negedge clk);
    check("abort_no_done", {30'd0, done, mem_wen}, 32'd0);
    check("abort_nwrites", 32'(act_q.size() - base), 32'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("abort_wr%0d", k), (base + k < act_q.size()) ? act_q[base + k] : 32'hFFFF_FFFF,
            exp_q.pop_front());

    // start with len=0 and abort together: stays idle, words_done holds
    @(negedge clk);
    start = 1'b1; len = 16'd0; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start0", {14'd0, done, busy, words_done}, {16'd0, 16'd3});
    @(negedge clk);
    check("abort_start0_next", {31'd0, done}, 32'd0);

    // Asynchronous reset during the second WRITE cycle
    base = act_q.size();
    @(negedge clk);
    start = 1'b1; src_addr = 16'h0010; dst_addr = 16'h006F; len = 16'd4;
    @(negedge clk);
    start = 1'b0;
    wcnt = 0; cyc = 0;
    while (cyc < 40) begin
      if (mem_wen) wcnt++;
      if (wcnt == 2) break;
      @(negedge clk);
      cyc++;
    end
    check("rst_reached", {words_done, 16'(wcnt)}, {16'd1, 16'd2});
    rst = 1'b0;
    #1;
    check("rst_outputs", {12'd0, busy, done, mem_wen, 1'b0, words_done}, 32'd0);
    check("rst_bus", {mem_addr, mem_wdata}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("rst_no_write", {mem[16'h0070], 16'(act_q.size() - base)}, {16'hDEAD, 16'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
